dma_channel_arbiter: RTL

Multi-channel front end for the single `dma_controller`. It accepts transfer descriptors from NCH requesters and arbitrates among them round-robin. It validates each descriptor, then drives `dma_controller`'s trigger/length/address inputs for one transfer at a time and waits for `done`. Each requester receives a completion pulse with error status, so software agents can share one AXI4-Lite DMA engine.

---
 rtl/dma_channel_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
//   Round-robin front end that lets NCH requesters share one dma_controller.
//   Each channel presents a descriptor (src/dst/len) with a request level.
//   The arbiter grants one channel at a time, checks its descriptor, triggers
//   the engine, waits for done (or a timeout), and answers with a one-cycle
//   ack plus error flag.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   ch_req[NCH]       per-channel request level, held until ch_ack
//   ch_src/ch_dst     NCH packed 32-bit addresses, channel i at [32i+:32]
//   ch_len            NCH packed 5-bit byte lengths, channel i at [5i+:5]
//   ch_ack/ch_err     one-hot completion pulse and its error status
//   dma_trigger       one-cycle start pulse to dma_controller
//   dma_length/src/dst  descriptor of the granted channel, held until next grant
//   dma_done          completion pulse from dma_controller
//   busy              high whenever a channel is being served
//   grant_id          index of the channel being served

// Descriptor legality: non-zero word-multiple length, word-aligned addresses.
// A 5-bit length that is a multiple of 4 tops out at 28 by construction.
module dma_desc_check (
    input  logic [31:0] src,
    input  logic [31:0] dst,
    input  logic [4:0]  len,
    output logic        ok
);
    assign ok = (len != 5'd0) && (len[1:0] == 2'b00) &&
                (src[1:0] == 2'b00) && (dst[1:0] == 2'b00);
endmodule

module dma_channel_arbiter #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH*32-1:0]       ch_src,
    input  logic [NCH*32-1:0]       ch_dst,
    input  logic [NCH*5-1:0]        ch_len,
    output logic [NCH-1:0]          ch_ack,
    output logic [NCH-1:0]          ch_err,
    output logic                    dma_trigger,
    output logic [4:0]              dma_length,
    output logic [31:0]             dma_src,
    output logic [31:0]             dma_dst,
    input  logic                    dma_done,
    output logic                    busy,
    output logic [$clog2(NCH)-1:0]  grant_id
);
    localparam int GW = $clog2(NCH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [4:0]  len;
    } dma_desc_t;

    state_t                 state_q, state_d;
    dma_desc_t [NCH-1:0]    desc;
    logic      [NCH-1:0]    ch_ok;
    logic      [GW-1:0]     last_grant;
    logic      [GW-1:0]     win_id;
    logic      [GW-1:0]     idx;
    logic                   win_found;
    logic                   latch;
    logic                   err_q, err_d;
    logic      [CW-1:0]     cnt_q, cnt_d;

    // Per-channel descriptor unpack and legality check.
    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_lane
            assign desc[g] = '{src: ch_src[32*g +: 32],
                               dst: ch_dst[32*g +: 32],
                               len: ch_len[5*g +: 5]};
            dma_desc_check u_chk (
                .src (desc[g].src),
                .dst (desc[g].dst),
                .len (desc[g].len),
                .ok  (ch_ok[g])
            );
        end
    endgenerate

    // Round-robin pick: first requester at or after last_grant+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = GW'((int'(last_grant) + 1 + i) % NCH);
            if (!win_found && ch_req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    latch = 1'b1;
                    if (ch_ok[win_id]) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = ACK;
                        err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
                // done takes precedence over a same-cycle terminal count
                if (dma_done) begin
                    state_d = ACK;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: descriptor registers change only on a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GW'(NCH - 1);
            grant_id   <= '0;
            dma_src    <= '0;
            dma_dst    <= '0;
            dma_length <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
            if (latch) begin
                last_grant <= win_id;
                grant_id   <= win_id;
                dma_src    <= desc[win_id].src;
                dma_dst    <= desc[win_id].dst;
                dma_length <= desc[win_id].len;
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign dma_trigger = (state_q == ISSUE);
    assign ch_ack      = (state_q == ACK) ? (NCH'(1) << grant_id) : '0;
    assign ch_err      = ch_ack & {NCH{err_q}};

endmodule
